// File: rtl/keycode_frame_decoder.sv
// Turns the raw two-slot HID keycode into frame-aligned direction, hold-count
// and auto-repeating action strobes. Frame boundaries come from VGA vertical sync.
`timescale 1ns/1ps
module keycode_frame_decoder #(
   parameter logic [7:0]  KEY_UP        = 8'h1A,
   parameter logic [7:0]  KEY_LEFT      = 8'h04,
   parameter logic [7:0]  KEY_DOWN      = 8'h16,
   parameter logic [7:0]  KEY_RIGHT     = 8'h07,
   parameter logic [7:0]  KEY_ACTION    = 8'h2C,
   parameter int unsigned REPEAT_FRAMES = 15
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        vs,
   input  logic [15:0] keycode,
   output logic        frame_tick,
   output logic [3:0]  dir,
   output logic        action_pulse,
   output logic [7:0]  hold_frames
);

   localparam logic [7:0] REP_LAST = 8'(REPEAT_FRAMES - 32'd1);

   typedef enum logic [1:0] {
      A_IDLE   = 2'd0,
      A_WAIT   = 2'd1,
      A_REPEAT = 2'd2
   } act_state_t;

   logic        vs_s1, vs_s2, vs_d;
   logic [15:0] kc_q;
   logic        up_p, down_p, left_p, right_p, act;
   logic [3:0]  dir_c;
   logic [7:0]  hold_c;
   act_state_t  state, state_next;
   logic [7:0]  cnt, cnt_next;
   logic        pulse_c;

   // vs synchronizer, edge register and registered falling-edge tick
   always_ff @(posedge Clk) begin
      if (Reset) begin
         vs_s1      <= 1'b1;
         vs_s2      <= 1'b1;
         vs_d       <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         vs_s1      <= vs;
         vs_s2      <= vs_s1;
         vs_d       <= vs_s2;
         frame_tick <= vs_d & ~vs_s2;
      end
   end

   // keycode capture; everything downstream decodes from this copy
   always_ff @(posedge Clk) begin
      if (Reset) kc_q <= 16'h0000;
      else       kc_q <= keycode;
   end

   // key decode from either slot, with opposite-direction cancellation
   always_comb begin
      up_p    = (kc_q[7:0] == KEY_UP)     || (kc_q[15:8] == KEY_UP);
      down_p  = (kc_q[7:0] == KEY_DOWN)   || (kc_q[15:8] == KEY_DOWN);
      left_p  = (kc_q[7:0] == KEY_LEFT)   || (kc_q[15:8] == KEY_LEFT);
      right_p = (kc_q[7:0] == KEY_RIGHT)  || (kc_q[15:8] == KEY_RIGHT);
      act     = (kc_q[7:0] == KEY_ACTION) || (kc_q[15:8] == KEY_ACTION);
      dir_c   = {up_p & ~down_p, down_p & ~up_p, left_p & ~right_p, right_p & ~left_p};
   end

   // next hold count: cleared when idle, saturating while unchanged, else restart
   always_comb begin
      hold_c = 8'd1;
      if (dir_c == 4'b0000)
         hold_c = 8'd0;
      else if (dir_c == dir)
         hold_c = (hold_frames == 8'hFF) ? 8'hFF : hold_frames + 8'd1;
   end

   // direction and hold count update once per frame
   always_ff @(posedge Clk) begin
      if (Reset) begin
         dir         <= 4'b0000;
         hold_frames <= 8'd0;
      end else if (frame_tick) begin
         dir         <= dir_c;
         hold_frames <= hold_c;
      end
   end

   // action FSM state register and registered strobe
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state        <= A_IDLE;
         cnt          <= 8'd0;
         action_pulse <= 1'b0;
      end else begin
         state        <= state_next;
         cnt          <= cnt_next;
         action_pulse <= pulse_c;
      end
   end

   // action FSM next state: first press fires, then fires every REPEAT_FRAMES frames
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      pulse_c    = 1'b0;
      if (frame_tick) begin
         case (state)
            A_IDLE: begin
               if (act) begin
                  pulse_c    = 1'b1;
                  cnt_next   = 8'd0;
                  state_next = A_WAIT;
               end
            end
            A_WAIT, A_REPEAT: begin
               if (!act) begin
                  state_next = A_IDLE;
                  cnt_next   = 8'd0;
               end else if (cnt == REP_LAST) begin
                  pulse_c    = 1'b1;
                  cnt_next   = 8'd0;
                  state_next = A_REPEAT;
               end else begin
                  cnt_next = cnt + 8'd1;
               end
            end
            default: begin
               state_next = A_IDLE;
               cnt_next   = 8'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keycode_frame_decoder.sv
// Randomized and directed bench for keycode_frame_decoder against a frame-level model.
`timescale 1ns/1ps
module tb_keycode_frame_decoder;

   logic        clk;
   logic        reset;
   logic        vs;
   logic [15:0] keycode;
   logic        frame_tick;
   logic [3:0]  dir;
   logic        action_pulse;
   logic [7:0]  hold_frames;

   int n_checks = 0;
   int n_fail   = 0;

   // frame-level reference state
   logic [3:0] m_dir;
   int         m_hold;
   int         m_run;

   keycode_frame_decoder dut (
      .Clk          (clk),
      .Reset        (reset),
      .vs           (vs),
      .keycode      (keycode),
      .frame_tick   (frame_tick),
      .dir          (dir),
      .action_pulse (action_pulse),
      .hold_frames  (hold_frames)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic has_key(input logic [15:0] kc, input logic [7:0] code);
      return (kc[7:0] == code) || (kc[15:8] == code);
   endfunction

   // direction the rules give for a keycode: {up,down,left,right}
   function automatic logic [3:0] ref_dir(input logic [15:0] kc);
      logic u, d, l, r;
      u = has_key(kc, 8'h1A);
      d = has_key(kc, 8'h16);
      l = has_key(kc, 8'h04);
      r = has_key(kc, 8'h07);
      if (u && d) begin u = 1'b0; d = 1'b0; end
      if (l && r) begin l = 1'b0; r = 1'b0; end
      return {u, d, l, r};
   endfunction

   function automatic logic [7:0] rand_slot();
      case ($urandom_range(0, 7))
         0: return 8'h1A;
         1: return 8'h04;
         2: return 8'h16;
         3: return 8'h07;
         4: return 8'h2C;
         5: return 8'($urandom_range(0, 255));
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_reset();
      m_dir  = 4'b0000;
      m_hold = 0;
      m_run  = 0;
   endtask

   // one frame: present kc, drop vs, check tick latency and post-tick outputs
   task automatic do_frame(input logic [15:0] kc);
      logic [3:0] nd;
      logic       exp_pulse;
      int         lat;
      @(negedge clk);
      keycode = kc;
      vs      = 1'b1;
      repeat (3) @(negedge clk);
      check("dir_between_ticks", 32'(dir), 32'(m_dir));
      vs = 1'b0;
      lat = 0;
      for (int i = 1; i <= 10 && lat == 0; i++) begin
         @(negedge clk);
         if (frame_tick) lat = i;
         else check("pulse_before_tick", 32'(action_pulse), 32'd0);
      end
      check("tick_latency", 32'(lat), 32'd3);
      nd = ref_dir(kc);
      if (nd == 4'b0000)  m_hold = 0;
      else if (nd == m_dir) m_hold = (m_hold >= 255) ? 255 : m_hold + 1;
      else                m_hold = 1;
      m_dir = nd;
      if (has_key(kc, 8'h2C)) m_run++;
      else                    m_run = 0;
      exp_pulse = (m_run > 0) && (((m_run - 1) % 15) == 0);
      @(negedge clk);
      check("tick_width", 32'(frame_tick), 32'd0);
      check("dir", 32'(dir), 32'(m_dir));
      check("hold_frames", 32'(hold_frames), 32'(m_hold));
      check("action_pulse", 32'(action_pulse), 32'(exp_pulse));
      @(negedge clk);
      check("pulse_width", 32'(action_pulse), 32'd0);
      vs = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      reset   = 1'b1;
      vs      = 1'b1;
      keycode = 16'h0000;
      model_reset();

      // reset held while vs toggles: no tick, outputs quiet
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         vs      = (i % 3 == 0) ? ~vs : vs;
         keycode = 16'h2C1A;
         check("rst_tick", 32'(frame_tick), 32'd0);
         check("rst_dir", 32'(dir), 32'd0);
         check("rst_pulse", 32'(action_pulse), 32'd0);
         check("rst_hold", 32'(hold_frames), 32'd0);
      end
      vs = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      check("post_rst_no_tick", 32'(frame_tick), 32'd0);

      // single up press, then long hold to saturation, then release
      do_frame(16'h001A);
      check("up_dir", 32'(dir), 32'b1000);
      check("up_hold", 32'(hold_frames), 32'd1);
      for (int i = 0; i < 299; i++) do_frame(16'h001A);
      check("hold_sat", 32'(hold_frames), 32'd255);
      do_frame(16'h0000);
      check("release_hold", 32'(hold_frames), 32'd0);

      // cancellation and diagonal
      do_frame(16'h0407);
      check("lr_cancel", 32'(dir), 32'd0);
      do_frame(16'h1A07);
      check("diag_dir", 32'(dir), 32'b1001);
      check("diag_hold", 32'(hold_frames), 32'd1);
      do_frame(16'h1A1A);
      check("dup_slot_dir", 32'(dir), 32'b1000);

      // held action, repeat every 15 frames
      for (int i = 0; i < 40; i++) do_frame(16'h2C00);
      do_frame(16'h0000);

      // short action blip between ticks is invisible
      do_frame(16'h0016);
      @(negedge clk);
      keycode = 16'h002C;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("blip_pulse", 32'(action_pulse), 32'd0);
         check("blip_dir", 32'(dir), 32'(m_dir));
      end
      keycode = 16'h0016;
      do_frame(16'h0016);

      // reset while the action FSM is waiting for repeat
      do_frame(16'h002C);
      do_frame(16'h002C);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("midrst_dir", 32'(dir), 32'd0);
      check("midrst_hold", 32'(hold_frames), 32'd0);
      check("midrst_pulse", 32'(action_pulse), 32'd0);
      check("midrst_tick", 32'(frame_tick), 32'd0);
      reset = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      do_frame(16'h002C);
      check("after_rst_pulse_frame1", 32'(action_pulse), 32'd0);

      // random runs of held keycodes
      for (int r = 0; r < 25; r++) begin
         logic [15:0] kc;
         int len;
         kc  = {rand_slot(), rand_slot()};
         len = $urandom_range(1, 20);
         for (int f = 0; f < len; f++) do_frame(kc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
